// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage driving the dual-bank register bank write pins
//
// Purpose: accepts one retiring instruction at a time, waits for its result from the
// ALU, data memory, input switches or the jal link path, then pulses Write or jal to
// the register bank for exactly one cycle. Stalls the core while a multi-cycle source
// is pending.
//
// Ports:
//   Clock_i                  clock, all state on posedge
//   Reset_i                  asynchronous active-low reset
//   WbValid_i / WbReady_o    instruction handshake (ready only in IDLE)
//   WbSrc_i                  0=ALU 1=MEM 2=IN 3=LINK
//   WbAddr_i, WbProc_i       destination register and bank select
//   AluResult_i              ALU result, sampled on transfer
//   MemData_i, MemReady_i    data-memory result
//   InputData_i              switch value, zero-extended
//   InputEnter_i             raw asynchronous Enter button
//   ProgramCounter_i/_o      PC, passed straight through to the bank for jal
//   Write_o, jal_o           one-cycle write / link-write pulses
//   AddrWrite_o, DataIn_o    bank write address and data (held between pulses)
//   select_proc_reg_write_o  bank select (held between pulses)
//   Stall_o                  high while not IDLE
//   TimeoutErr_o             sticky memory-timeout flag
module writeback_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int IN_WIDTH    = 16
) (
  input  logic                Clock_i,
  input  logic                Reset_i,
  input  logic                WbValid_i,
  output logic                WbReady_o,
  input  logic [1:0]          WbSrc_i,
  input  logic [4:0]          WbAddr_i,
  input  logic                WbProc_i,
  input  logic [31:0]         AluResult_i,
  input  logic [31:0]         MemData_i,
  input  logic                MemReady_i,
  input  logic [IN_WIDTH-1:0] InputData_i,
  input  logic                InputEnter_i,
  input  logic [31:0]         ProgramCounter_i,
  output logic [31:0]         ProgramCounter_o,
  output logic                Write_o,
  output logic                jal_o,
  output logic [4:0]          AddrWrite_o,
  output logic [31:0]         DataIn_o,
  output logic                select_proc_reg_write_o,
  output logic                Stall_o,
  output logic                TimeoutErr_o
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_IN   = 2'd2;
  localparam logic [1:0] SRC_LINK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_WAIT_PRESS,
    S_WAIT_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            jal_q, jal_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            sel_q, sel_d;
  logic [4:0]      pend_addr_q, pend_addr_d;
  logic            pend_proc_q, pend_proc_d;
  logic            terr_q, terr_d;
  logic            sync1_q, sync2_q, prev_q;
  logic            press;

  // Rising edge of the synchronized button; a button already held when WAIT_PRESS
  // is entered has prev_q=1 and so produces no edge until released and re-pressed.
  assign press = sync2_q & ~prev_q;

  always_ff @(posedge Clock_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      jal_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= 1'b0;
      pend_addr_q <= '0;
      pend_proc_q <= 1'b0;
      terr_q      <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      jal_q       <= jal_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      pend_addr_q <= pend_addr_d;
      pend_proc_q <= pend_proc_d;
      terr_q      <= terr_d;
      sync1_q     <= InputEnter_i;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = 1'b0;
    jal_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    pend_addr_d = pend_addr_q;
    pend_proc_d = pend_proc_q;
    terr_d      = terr_q;

    case (state_q)
      S_IDLE: begin
        if (WbValid_i) begin
          pend_addr_d = WbAddr_i;
          pend_proc_d = WbProc_i;
          case (WbSrc_i)
            SRC_ALU: begin
              write_d = 1'b1;
              addr_d  = WbAddr_i;
              data_d  = AluResult_i;
              sel_d   = WbProc_i;
            end
            SRC_MEM: begin
              state_d = S_WAIT_MEM;
              cnt_d   = '0;
            end
            SRC_IN: begin
              state_d = S_WAIT_PRESS;
            end
            SRC_LINK: begin
              // The bank computes PC+1 and targets r30 itself; address/data hold.
              jal_d = 1'b1;
              sel_d = WbProc_i;
            end
            default: ;
          endcase
        end
      end

      S_WAIT_MEM: begin
        // MemReady is checked first so a result on the final cycle still writes.
        if (MemReady_i) begin
          write_d = 1'b1;
          addr_d  = pend_addr_q;
          data_d  = MemData_i;
          sel_d   = pend_proc_q;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAIT_PRESS: begin
        if (press) begin
          write_d = 1'b1;
          addr_d  = pend_addr_q;
          data_d  = 32'(InputData_i);
          sel_d   = pend_proc_q;
          state_d = S_WAIT_RELEASE;
        end
      end

      S_WAIT_RELEASE: begin
        if (!sync2_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign WbReady_o               = (state_q == S_IDLE);
  assign Stall_o                 = (state_q != S_IDLE);
  assign Write_o                 = write_q;
  assign jal_o                   = jal_q;
  assign AddrWrite_o             = addr_q;
  assign DataIn_o                = data_q;
  assign select_proc_reg_write_o = sel_q;
  assign TimeoutErr_o            = terr_q;
  assign ProgramCounter_o        = ProgramCounter_i;

endmodule
